mips_cpu_muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU plus HI/LO ownership (MTHI/MTLO writes, MFHI/MFLO reads).

---
 rtl/mips_cpu_muldiv_seq_if.sv | 23 ++
 rtl/mips_cpu_muldiv_seq.sv | 159 +++++++++++++++
 tb/tb_mips_cpu_muldiv_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_muldiv_seq_if.sv
// rtl/mips_cpu_muldiv_seq_if.sv - control-unit to muldiv sequencer request/result bundle
interface mips_cpu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_cpu_muldiv_seq.sv
// rtl/mips_cpu_muldiv_seq.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
module mips_cpu_muldiv_seq #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = '1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mips_cpu_muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Mult: {partial high, multiplier remaining}; div: {remainder, quotient/dividend}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Mult: |multiplicand|; div: |divisor|
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh, rem_trial;
  logic               rem_borrow;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign bus.busy = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.done = (state_q == S_DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Next-state, datapath step and HI/LO update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    a_mag     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Shift-add: conditionally add multiplicand into the high half, then shift right
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // Restoring divide: remainder after shift can need WIDTH+1 bits
    rem_sh     = acc_q[2*WIDTH-1:WIDTH-1];
    rem_borrow = rem_sh < {1'b0, opnd_q};
    rem_trial  = rem_sh - {1'b0, opnd_q};
    div_next   = rem_borrow ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                            : {rem_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod_fix = neg_res_q ? -acc_q : acc_q;
    quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              acc_d     = {{WIDTH{1'b0}}, b_mag};
              opnd_d    = a_mag;
              is_div_d  = 1'b0;
              neg_res_d = signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_rem_d = 1'b0;
              div0_d    = 1'b0;
              cnt_d     = '0;
              state_d   = S_CALC;
            end
            OP_DIV, OP_DIVU: begin
              acc_d     = {{WIDTH{1'b0}}, a_mag};
              opnd_d    = b_mag;
              is_div_d  = 1'b1;
              neg_res_d = signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_rem_d = signed_op && bus.a[WIDTH-1];
              div0_d    = (bus.b == '0);
              cnt_d     = '0;
              state_d   = S_CALC;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          // A zero divisor never borrows, so the remainder ends as |a| and
          // the sign fix restores the original dividend for hi.
          lo_d = div0_q ? DIV0_LO : quot_fix;
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end
endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// tb/tb_mips_cpu_muldiv_seq.sv - directed vector bench for mips_cpu_muldiv_seq
module tb_mips_cpu_muldiv_seq;
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic clk;
  logic reset_n;
  int   pass_cnt;
  int   total_cnt;
  vec_t vecs[12];

  mips_cpu_muldiv_seq_if #(.WIDTH(32)) bus ();

  mips_cpu_muldiv_seq #(.WIDTH(32), .DIV0_LO(32'hFFFFFFFF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts op at the next edge, waits for done, checks latency and result
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int lat;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    step();
    bus.start = 1'b0;
    bus.op    = OP_NONE;
    chk({name, " busy_after_accept"}, {31'b0, bus.busy}, 32'd1);
    lat = 0;
    while (!bus.done && lat < 40) begin
      step();
      lat++;
    end
    chk({name, " latency"}, lat, 32'd33);
    chk({name, " hi"}, bus.hi, exp_hi);
    chk({name, " lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    vecs[0]  = '{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{"mult_m3x7",   OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{"mult_minsq",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{"multu_shift", OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[4]  = '{"div_m7d2",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5]  = '{"divu_7d2",    OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3};
    vecs[6]  = '{"div_min_m1",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7]  = '{"divu_by0",    OP_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
    vecs[8]  = '{"div_neg_by0", OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{"div_100_m7",  OP_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2};
    vecs[10] = '{"div_m100_m7", OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};
    vecs[11] = '{"divu_big",    OP_DIVU,  32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF};

    bus.start = 1'b0;
    bus.op    = OP_NONE;
    bus.a     = '0;
    bus.b     = '0;
    reset_n   = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset done", {31'b0, bus.done}, 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);

    // Table-driven arithmetic, each followed by a done-width check
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);
      step();
      chk({vecs[i].name, " done_width"}, {31'b0, bus.done}, 32'd0);
    end

    // MTLO / MTHI in IDLE
    bus.start = 1'b1; bus.op = OP_MTLO; bus.a = 32'hCAFEBABE;
    step();
    bus.start = 1'b0; bus.op = OP_NONE;
    chk("mtlo lo", bus.lo, 32'hCAFEBABE);
    chk("mtlo busy", {31'b0, bus.busy}, 32'd0);
    chk("mtlo done", {31'b0, bus.done}, 32'd0);
    step();
    chk("mtlo done_later", {31'b0, bus.done}, 32'd0);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'h11223344;
    step();
    bus.start = 1'b0; bus.op = OP_NONE;
    chk("mthi hi", bus.hi, 32'h11223344);
    chk("mthi lo_kept", bus.lo, 32'hCAFEBABE);

    // Ops issued mid-CALC are ignored
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd5; bus.b = 32'd6;
    step();
    bus.start = 1'b0; bus.op = OP_NONE;
    for (int i = 0; i < 5; i++) step();
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'hDEADBEEF;
    step();
    chk("midcalc mthi hi", bus.hi, 32'h11223344);
    bus.op = OP_DIV; bus.a = 32'd9; bus.b = 32'd3;
    step();
    bus.start = 1'b0; bus.op = OP_NONE;
    chk("midcalc div busy", {31'b0, bus.busy}, 32'd1);
    chk("midcalc hi", bus.hi, 32'h11223344);
    chk("midcalc lo", bus.lo, 32'hCAFEBABE);
    begin
      int lat;
      lat = 7;
      while (!bus.done && lat < 40) begin
        step();
        lat++;
      end
      chk("midcalc latency", lat, 32'd33);
      chk("midcalc result hi", bus.hi, 32'd0);
      chk("midcalc result lo", bus.lo, 32'd30);
    end

    // Back-to-back: new op accepted during the DONE cycle
    run_op("b2b_divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    // Reset at CALC counter 10 aborts the op with no done pulse
    bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd1000; bus.b = 32'd3;
    step();
    bus.start = 1'b0; bus.op = OP_NONE;
    for (int i = 0; i < 10; i++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort busy", {31'b0, bus.busy}, 32'd0);
    chk("abort done", {31'b0, bus.done}, 32'd0);
    chk("abort hi", bus.hi, 32'd0);
    chk("abort lo", bus.lo, 32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (bus.done || bus.busy) seen++;
      end
      chk("abort no_done", seen, 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
